// File: rtl/prime_ticker_pkg.sv
// Shared types and elaboration-time helpers for prime_ticker.
// No logic; constant functions size the timers and the LED page count.
// No flow control.
package prime_ticker_pkg;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GUARD = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // Divide first so large board clocks stay inside 32 bits.
    function automatic int ms_to_cycles(input int hz, input int ms);
        return (hz / 1000) * ms;
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/prime_ticker_interval_timer.sv
// Free-running divider: tick is high for one cycle when the count reaches DIV-1, then wraps.
// Latency: tick decoded from the count register, no extra delay.
// No backpressure; runs every cycle except under reset.
module interval_timer
    import prime_ticker_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/prime_ticker.sv
// Paces primogen requests, latches each prime and pages it onto the LEDs; PRIME_TICKER_BLINK_EN blinks LEDs when halted.
// Latency: pg_go one cycle after request condition; leds one cycle after page changes.
// Backpressure: waits on pg_ready and pause; surplus request ticks collapse into one pending flag.
module prime_ticker
    import prime_ticker_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int NLEDS     = 5,
    parameter int CNT_W     = 16,
    parameter int CLK_HZ    = 12000000,
    parameter int PERIOD_MS = 5000,
    parameter int PAGE_MS   = 1000
) (
    input  logic             clk,
    input  logic             rst,
    output logic             pg_go,
    input  logic             pg_ready,
    input  logic             pg_error,
    input  logic [WIDTH-1:0] pg_res,
    input  logic             pause,
    output logic [NLEDS-1:0] leds,
    output logic [WIDTH-1:0] prime,
    output logic [CNT_W-1:0] count,
    output logic             halted
);

    localparam int REQ_DIV = ms_to_cycles(CLK_HZ, PERIOD_MS);
    localparam int PAGE_DIV = ms_to_cycles(CLK_HZ, PAGE_MS);
    localparam int NPAGES = ceil_div(WIDTH, NLEDS);
    localparam int PAD_W = NPAGES * NLEDS;
    localparam int PAGE_W = (NPAGES > 1) ? $clog2(NPAGES) : 1;

    logic req_tick;
    logic page_tick;

    interval_timer #(.DIV(REQ_DIV)) u_req_timer (
        .clk  (clk),
        .rst  (rst),
        .tick (req_tick)
    );

    interval_timer #(.DIV(PAGE_DIV)) u_page_timer (
        .clk  (clk),
        .rst  (rst),
        .tick (page_tick)
    );

    state_t             state_q, state_d;
    logic               pg_go_q, pg_go_d;
    logic [WIDTH-1:0]   prime_q, prime_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               halted_q, halted_d;
    logic               pending_q, pending_d;
    logic [PAGE_W-1:0]  page_q, page_d;
    logic [NLEDS-1:0]   leds_q, leds_d;
    logic               issue;
    logic [PAD_W-1:0]   padded;
    logic [NLEDS-1:0]   page_leds;

    // Bits past WIDTH on the last page read as zero.
    always_comb begin
        padded = '0;
        padded[WIDTH-1:0] = prime_q;
        page_leds = '0;
        for (int p = 0; p < NPAGES; p++) begin
            if (page_q == PAGE_W'(p)) begin
                page_leds = padded[p*NLEDS +: NLEDS];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        pg_go_d  = 1'b0;
        prime_d  = prime_q;
        count_d  = count_q;
        halted_d = halted_q;
        issue    = 1'b0;

        case (state_q)
            ST_WAIT: begin
                if (pg_error) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else if ((pending_q || req_tick) && pg_ready && !pause) begin
                    issue   = 1'b1;
                    state_d = ST_ISSUE;
                    pg_go_d = 1'b1;
                    prime_d = pg_res;
                    count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);
                end
            end
            // primogen samples go during ISSUE; give it one cycle before trusting ready again.
            ST_ISSUE: state_d = ST_GUARD;
            ST_GUARD: state_d = ST_WAIT;
            ST_HALT: halted_d = 1'b1;
            default: state_d = ST_WAIT;
        endcase

        if (issue) begin
            pending_d = 1'b0;
        end else if (req_tick) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end

        if (issue) begin
            page_d = '0;
        end else if (page_tick) begin
            page_d = (page_q == PAGE_W'(NPAGES - 1)) ? '0 : page_q + PAGE_W'(1);
        end else begin
            page_d = page_q;
        end

`ifdef PRIME_TICKER_BLINK_EN
        if (state_q == ST_HALT) begin
            leds_d = leds_q;
            if (page_tick) begin
                leds_d = (leds_q == '1) ? '0 : '1;
            end
        end else begin
            leds_d = page_leds;
        end
`else
        leds_d = page_leds;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_WAIT;
            pg_go_q   <= 1'b0;
            prime_q   <= '0;
            count_q   <= '0;
            halted_q  <= 1'b0;
            pending_q <= 1'b0;
            page_q    <= '0;
            leds_q    <= '0;
        end else begin
            state_q   <= state_d;
            pg_go_q   <= pg_go_d;
            prime_q   <= prime_d;
            count_q   <= count_d;
            halted_q  <= halted_d;
            pending_q <= pending_d;
            page_q    <= page_d;
            leds_q    <= leds_d;
        end
    end

    assign pg_go  = pg_go_q;
    assign prime  = prime_q;
    assign count  = count_q;
    assign halted = halted_q;
    assign leds   = leds_q;

endmodule

// File: tb/tb_prime_ticker.sv
// Directed bench for prime_ticker at WIDTH=8 NLEDS=3, 4-cycle request and 2-cycle page intervals.
// Edge k counts clock edges after reset release; outputs are sampled 1 time unit after each edge.
module tb_prime_ticker;

    logic       clk = 1'b0;
    logic       rst;
    logic       pg_go;
    logic       pg_ready;
    logic       pg_error;
    logic [7:0] pg_res;
    logic       pause;
    logic [2:0] leds;
    logic [7:0] prime;
    logic [7:0] count;
    logic       halted;

    int errors = 0;
    int checks = 0;
    int k = 0;

    logic [2:0] page_exp [8];
    logic [2:0] halt_exp [6];

    prime_ticker #(
        .WIDTH     (8),
        .NLEDS     (3),
        .CNT_W     (8),
        .CLK_HZ    (1000),
        .PERIOD_MS (4),
        .PAGE_MS   (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pg_go    (pg_go),
        .pg_ready (pg_ready),
        .pg_error (pg_error),
        .pg_res   (pg_res),
        .pause    (pause),
        .leds     (leds),
        .prime    (prime),
        .count    (count),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    initial begin
        page_exp = '{3'b101, 3'b101, 3'b110, 3'b110, 3'b010, 3'b010, 3'b101, 3'b101};
`ifdef PRIME_TICKER_BLINK_EN
        halt_exp = '{3'b110, 3'b111, 3'b111, 3'b000, 3'b000, 3'b111};
`else
        halt_exp = '{3'b010, 3'b010, 3'b101, 3'b101, 3'b110, 3'b110};
`endif

        rst      = 1'b1;
        pg_ready = 1'b0;
        pg_error = 1'b0;
        pg_res   = 8'd0;
        pause    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_go", pg_go, 0);
        chk("rst_leds", leds, 0);
        chk("rst_prime", prime, 0);
        chk("rst_count", count, 0);
        chk("rst_halted", halted, 0);

        // Steady requests: go on every 4th edge, never before the first tick.
        rst      = 1'b0;
        pg_ready = 1'b1;
        pg_res   = 8'd7;
        for (int i = 1; i <= 12; i++) begin
            step();
            chk("steady_go", pg_go, (k % 4 == 0));
            if (k % 4 == 0) begin
                chk("steady_count", count, k / 4);
                chk("steady_prime", prime, 7);
            end
        end

        // Not ready across the tick at edge 16; ready from edge 18 gives go at 19 only.
        pg_ready = 1'b0;
        for (int i = 13; i <= 21; i++) begin
            step();
            chk("late_ready_go", pg_go, (k == 19));
            if (k == 18) pg_ready = 1'b1;
            if (k == 19) begin
                pg_ready = 1'b0;
                pg_res   = 8'hB5;
                chk("late_ready_count", count, 4);
            end
        end

        // Pending from the edge-20 tick issues 0xB5 at edge 22.
        pg_ready = 1'b1;
        step();
        chk("b5_go", pg_go, 1);
        chk("b5_prime", prime, 8'hB5);
        chk("b5_count", count, 5);
        pg_ready = 1'b0;

        for (int i = 0; i < 8; i++) begin
            step();
            chk("page_leds", leds, page_exp[i]);
            chk("page_go", pg_go, 0);
        end

        // Pause across ticks at 32, 36, 40; release yields a single request.
        pause    = 1'b1;
        pg_ready = 1'b1;
        for (int i = 31; i <= 41; i++) begin
            step();
            chk("pause_go", pg_go, 0);
        end
        pause = 1'b0;
        step();
        chk("unpause_go", pg_go, 1);
        chk("unpause_count", count, 6);
        pg_ready = 1'b0;
        for (int i = 43; i <= 45; i++) begin
            step();
            chk("unpause_quiet", pg_go, 0);
        end

        // Error wins over a pending, ready request.
        pg_error = 1'b1;
        pg_ready = 1'b1;
        step();
        chk("halt_flag", halted, 1);
        chk("halt_go", pg_go, 0);
        chk("halt_count", count, 6);
        pg_error = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("halt_go_hold", pg_go, 0);
            chk("halt_sticky", halted, 1);
            chk("halt_count_frozen", count, 6);
            chk("halt_prime_frozen", prime, 8'hB5);
            chk("halt_leds", leds, halt_exp[i]);
        end

        rst = 1'b1;
        step();
        chk("rst2_count", count, 0);
        chk("rst2_halted", halted, 0);
        chk("rst2_prime", prime, 0);
        chk("rst2_leds", leds, 0);
        chk("rst2_go", pg_go, 0);
        rst = 1'b0;
        step();
        chk("rst2_after_go", pg_go, 0);
        chk("rst2_after_halted", halted, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
